// File: rtl/mips_core_pkg.sv
// Shared MIPS core types and constants used by the front-end queues.
package mips_core_pkg;

  localparam int unsigned INST_Q_DEPTH = 8;
  localparam int unsigned XLEN         = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } inst_q_entry;

  function automatic inst_q_entry inst_q_pack(input logic [XLEN-1:0] pc,
                                              input logic [XLEN-1:0] inst);
    inst_q_entry e;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO with flush; full/empty/count derived from pointers.
// Optional same-cycle empty-queue bypass enabled by defining INST_Q_BYPASS_EN.
module inst_queue
  import mips_core_pkg::*;
#(
  parameter int unsigned DEPTH = INST_Q_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_inst,
  input  logic                     pop_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  inst_q_entry   mem [DEPTH];

  logic          push_acc;
  logic          wr_en;
  logic          rd_adv;
  logic          head_valid;
  inst_q_entry   head;

  // Pointer MSB distinguishes a wrapped (full) queue from an empty one.
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push_acc = push_valid && !full && !flush;

`ifdef INST_Q_BYPASS_EN
  logic bypass;
  // An accepted push into an empty queue is presented at the head immediately;
  // if decode takes it that cycle it is never written.
  always_comb begin
    bypass     = empty && push_acc;
    head_valid = !empty || bypass;
    head       = bypass ? inst_q_pack(push_pc, push_inst) : mem[rd_ptr[AW-1:0]];
    wr_en      = push_acc && !(bypass && pop_ready);
    rd_adv     = pop_ready && !empty && !flush;
  end
`else
  always_comb begin
    head_valid = !empty;
    head       = mem[rd_ptr[AW-1:0]];
    wr_en      = push_acc;
    rd_adv     = pop_ready && !empty && !flush;
  end
`endif

  // Head outputs are forced to zero whenever nothing is presented.
  always_comb begin
    out_valid = head_valid;
    out_pc    = '0;
    out_inst  = '0;
    if (head_valid) begin
      out_pc   = head.pc;
      out_inst = head.inst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage holds no reset; stale entries are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= inst_q_pack(push_pc, push_inst);
  end

endmodule
